// File: rtl/decade_down_timer.sv
`default_nettype none
// ============================================================================
// Module      : decade_down_timer
// Description : Cascaded BCD down-counter with load/start control, optional
//               auto-reload, a RUN indicator and a one-cycle expiry pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module decade_down_timer #(
    parameter int DIGITS      = 2,   // number of BCD digits, 1..4
    parameter int AUTO_RELOAD = 0    // 1: restart from reload value on expiry
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  done
);

    localparam int c_WIDTH = 4 * DIGITS;
    localparam logic [c_WIDTH-1:0] c_ONE = {{(c_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_WIDTH-1:0]   count_q, count_d;
    logic [c_WIDTH-1:0]   reload_q, reload_d;
    logic                 done_q, done_d;
    logic [c_WIDTH-1:0]   w_load_clamped;

    // Any preset digit above 9 is saturated so the count stays valid BCD.
    for (genvar g = 0; g < DIGITS; g++) begin : g_clamp
        assign w_load_clamped[4*g +: 4] =
            (load_val[4*g +: 4] > 4'd9) ? 4'd9 : load_val[4*g +: 4];
    end

    // One BCD decrement: a zero digit wraps to 9 and keeps borrowing upward.
    function automatic logic [c_WIDTH-1:0] bcd_dec(input logic [c_WIDTH-1:0] value);
        logic [c_WIDTH-1:0] result;
        logic               borrow;
        result = value;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (value[4*i +: 4] == 4'd0) begin
                    result[4*i +: 4] = 4'd9;
                end else begin
                    result[4*i +: 4] = value[4*i +: 4] - 4'd1;
                    borrow           = 1'b0;
                end
            end
        end
        return result;
    endfunction

    // State, count, reload and pulse registers; reset clears everything at once.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic; load overrides start, which overrides en.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (load) begin
            count_d  = w_load_clamped;
            reload_d = w_load_clamped;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A zero count has nothing to time, so start is dropped.
                    if (start && (count_q != '0)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // start is deliberately ignored while counting.
                    if (en) begin
                        count_d = bcd_dec(count_q);
                        if (count_q == c_ONE) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Restart from the reload value on request, or unconditionally
                    // when auto-reload is enabled; a zero reload value stays put.
                    if ((start || (AUTO_RELOAD != 0)) && (reload_q != '0)) begin
                        count_d = reload_q;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign count   = count_q;
    assign running = (state_q == ST_RUN);
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_decade_down_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_decade_down_timer
// Description : Directed, table-driven bench for decade_down_timer covering
//               a 2-digit stop-at-zero instance, a 3-digit instance and a
//               2-digit auto-reload instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decade_down_timer;

    typedef struct {
        int          sel;      // 0: 2-digit, 1: 3-digit, 2: 2-digit auto-reload
        logic        ld;
        logic [15:0] lv;
        logic        st;
        logic        en;
        logic [15:0] cnt;
        logic        run;
        logic        dn;
    } vec_t;

    logic        clock;
    logic        rst_n;

    logic        a_en, a_load, a_start, a_running, a_done;
    logic [7:0]  a_load_val, a_count;
    logic        b_en, b_load, b_start, b_running, b_done;
    logic [11:0] b_load_val, b_count;
    logic        c_en, c_load, c_start, c_running, c_done;
    logic [7:0]  c_load_val, c_count;

    int errors = 0;
    int checks = 0;
    vec_t vq[$];

    decade_down_timer #(.DIGITS(2), .AUTO_RELOAD(0)) dut_a (
        .clock(clock), .rst_n(rst_n), .en(a_en), .load(a_load),
        .load_val(a_load_val), .start(a_start), .count(a_count),
        .running(a_running), .done(a_done)
    );

    decade_down_timer #(.DIGITS(3), .AUTO_RELOAD(0)) dut_b (
        .clock(clock), .rst_n(rst_n), .en(b_en), .load(b_load),
        .load_val(b_load_val), .start(b_start), .count(b_count),
        .running(b_running), .done(b_done)
    );

    decade_down_timer #(.DIGITS(2), .AUTO_RELOAD(1)) dut_c (
        .clock(clock), .rst_n(rst_n), .en(c_en), .load(c_load),
        .load_val(c_load_val), .start(c_start), .count(c_count),
        .running(c_running), .done(c_done)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input int sel, input logic ld, input logic [15:0] lv,
                       input logic st, input logic en, input logic [15:0] cnt,
                       input logic run, input logic dn);
        vec_t v;
        v.sel = sel; v.ld = ld; v.lv = lv; v.st = st; v.en = en;
        v.cnt = cnt; v.run = run; v.dn = dn;
        vq.push_back(v);
    endtask

    // Drive one vector, advance one edge, then compare the selected instance.
    task automatic apply(input int idx, input vec_t v);
        logic [15:0] act_cnt;
        logic        act_run, act_dn;
        a_load = 1'b0; a_start = 1'b0; a_en = 1'b0; a_load_val = '0;
        b_load = 1'b0; b_start = 1'b0; b_en = 1'b0; b_load_val = '0;
        c_load = 1'b0; c_start = 1'b0; c_en = 1'b0; c_load_val = '0;
        case (v.sel)
            0: begin a_load = v.ld; a_start = v.st; a_en = v.en; a_load_val = v.lv[7:0];  end
            1: begin b_load = v.ld; b_start = v.st; b_en = v.en; b_load_val = v.lv[11:0]; end
            default: begin c_load = v.ld; c_start = v.st; c_en = v.en; c_load_val = v.lv[7:0]; end
        endcase
        @(posedge clock);
        #1;
        case (v.sel)
            0: begin act_cnt = {8'h00, a_count}; act_run = a_running; act_dn = a_done; end
            1: begin act_cnt = {4'h0, b_count};  act_run = b_running; act_dn = b_done; end
            default: begin act_cnt = {8'h00, c_count}; act_run = c_running; act_dn = c_done; end
        endcase
        chk($sformatf("vec%0d count", idx),   act_cnt, v.cnt);
        chk($sformatf("vec%0d running", idx), {15'b0, act_run}, {15'b0, v.run});
        chk($sformatf("vec%0d done", idx),    {15'b0, act_dn},  {15'b0, v.dn});
    endtask

    initial begin
        logic [15:0] bcd;
        vec_t        v;

        // ---------------- vector table ----------------
        // 2-digit countdown 12 -> 00, done pulse, then hold in DONE
        add(0, 1, 16'h12, 0, 0, 16'h12, 0, 0);
        add(0, 0, 16'h00, 1, 0, 16'h12, 1, 0);
        for (int k = 11; k >= 1; k--) begin
            bcd = 16'(((k / 10) << 4) | (k % 10));
            add(0, 0, 16'h00, 0, 1, bcd, 1, 0);
        end
        add(0, 0, 16'h00, 0, 1, 16'h00, 0, 1);
        add(0, 0, 16'h00, 0, 1, 16'h00, 0, 0);
        add(0, 0, 16'h00, 0, 1, 16'h00, 0, 0);
        // load beats start; en low freezes; start in RUN ignored
        add(0, 1, 16'h05, 0, 0, 16'h05, 0, 0);
        add(0, 1, 16'h05, 1, 0, 16'h05, 0, 0);
        add(0, 0, 16'h00, 1, 0, 16'h05, 1, 0);
        add(0, 0, 16'h00, 0, 1, 16'h04, 1, 0);
        add(0, 0, 16'h00, 0, 0, 16'h04, 1, 0);
        add(0, 0, 16'h00, 1, 0, 16'h04, 1, 0);
        add(0, 0, 16'h00, 0, 1, 16'h03, 1, 0);
        add(0, 0, 16'h00, 0, 1, 16'h02, 1, 0);
        add(0, 0, 16'h00, 0, 1, 16'h01, 1, 0);
        add(0, 0, 16'h00, 0, 1, 16'h00, 0, 1);
        add(0, 0, 16'h00, 0, 0, 16'h00, 0, 0);
        // start in DONE restarts from reload value 05
        add(0, 0, 16'h00, 1, 0, 16'h05, 1, 0);
        add(0, 0, 16'h00, 0, 1, 16'h04, 1, 0);
        // load in RUN wins over en and returns to IDLE, where en does nothing
        add(0, 1, 16'h21, 0, 1, 16'h21, 0, 0);
        add(0, 0, 16'h00, 0, 1, 16'h21, 0, 0);
        // 3-digit borrow across two digits, then clamping
        add(1, 1, 16'h100, 0, 0, 16'h100, 0, 0);
        add(1, 0, 16'h000, 1, 0, 16'h100, 1, 0);
        add(1, 0, 16'h000, 0, 1, 16'h099, 1, 0);
        add(1, 0, 16'h000, 0, 1, 16'h098, 1, 0);
        add(1, 1, 16'hA5C, 0, 0, 16'h959, 0, 0);
        // auto-reload period of 4, reload happens even with en low
        add(2, 1, 16'h03, 0, 0, 16'h03, 0, 0);
        add(2, 0, 16'h00, 1, 0, 16'h03, 1, 0);
        add(2, 0, 16'h00, 0, 1, 16'h02, 1, 0);
        add(2, 0, 16'h00, 0, 1, 16'h01, 1, 0);
        add(2, 0, 16'h00, 0, 1, 16'h00, 0, 1);
        add(2, 0, 16'h00, 0, 0, 16'h03, 1, 0);
        add(2, 0, 16'h00, 0, 0, 16'h03, 1, 0);
        add(2, 0, 16'h00, 0, 1, 16'h02, 1, 0);
        add(2, 0, 16'h00, 0, 1, 16'h01, 1, 0);
        add(2, 0, 16'h00, 0, 1, 16'h00, 0, 1);
        add(2, 0, 16'h00, 0, 1, 16'h03, 1, 0);
        add(2, 0, 16'h00, 0, 1, 16'h02, 1, 0);

        // ---------------- reset ----------------
        rst_n = 1'b1;
        a_load = 0; a_start = 0; a_en = 0; a_load_val = '0;
        b_load = 0; b_start = 0; b_en = 0; b_load_val = '0;
        c_load = 0; c_start = 0; c_en = 0; c_load_val = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset count",   {8'h00, a_count}, 16'h0000);
        chk("reset running", {15'b0, a_running}, 16'h0000);
        chk("reset done",    {15'b0, a_done},    16'h0000);
        @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < vq.size(); i++) begin
            apply(i, vq[i]);
        end

        // ---------------- hand sequences ----------------
        // Out-of-range preset clamps both count and reload register.
        v = '{sel: 0, ld: 1, lv: 16'hAF, st: 0, en: 0, cnt: 16'h99, run: 0, dn: 0};
        apply(100, v);
        chk("clamp reload", {8'h00, dut_a.reload_q}, 16'h0099);

        // Asynchronous reset between edges while running at 07.
        v = '{sel: 0, ld: 1, lv: 16'h07, st: 0, en: 0, cnt: 16'h07, run: 0, dn: 0};
        apply(101, v);
        v = '{sel: 0, ld: 0, lv: 16'h00, st: 1, en: 0, cnt: 16'h07, run: 1, dn: 0};
        apply(102, v);
        a_start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async rst count",   {8'h00, a_count},   16'h0000);
        chk("async rst running", {15'b0, a_running}, 16'h0000);
        chk("async rst reload",  {8'h00, dut_a.reload_q}, 16'h0000);
        #1 rst_n = 1'b1;
        // First edge after release: start with count 0 must be ignored.
        v = '{sel: 0, ld: 0, lv: 16'h00, st: 1, en: 1, cnt: 16'h00, run: 0, dn: 0};
        apply(103, v);
        v = '{sel: 0, ld: 0, lv: 16'h00, st: 0, en: 1, cnt: 16'h00, run: 0, dn: 0};
        apply(104, v);
        // Block is still fully functional afterwards.
        v = '{sel: 0, ld: 1, lv: 16'h30, st: 0, en: 0, cnt: 16'h30, run: 0, dn: 0};
        apply(105, v);
        v = '{sel: 0, ld: 0, lv: 16'h00, st: 1, en: 0, cnt: 16'h30, run: 1, dn: 0};
        apply(106, v);
        v = '{sel: 0, ld: 0, lv: 16'h00, st: 0, en: 1, cnt: 16'h29, run: 1, dn: 0};
        apply(107, v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
